spi_reg_master: RTL and testbench

- SPI master that issues the two-byte register transaction the FPGA's SPI register interface expects.
- Frame: byte 0 = {rw, addr[6:0]} (rw 1 = write, 0 = read); byte 1 = write data (master to slave) and read data (slave to master) at the same time.
- Used to drive external SPI peripherals and as the bench initiator for the on-chip spi_slave register map (0x00 FPGA_FW_VERSION RO, 0x01 AEROFC_FORCE_BT RW).
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, one chip select, runs on the 50 MHz core clock.

---
 rtl/spi_reg_master_if.sv | 23 ++
 rtl/spi_reg_master.sv | 200 ++++++++++++++++++++
 tb/tb_spi_reg_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_master_if.sv
// Request/response bus of the SPI register master: one transaction request
// in, busy/done status and the received data byte out.
interface spi_reg_master_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  // Initiator side (issues transactions)
  modport master (
    output start, rw, addr, wdata,
    input  busy, done, rdata
  );

  // SPI master side (serves transactions)
  modport slave (
    input  start, rw, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master. One transaction is a 16-bit frame:
// byte 0 = {rw, addr}, byte 1 = write data out / read data in, MSB first.
// SCLK half period is CLK_DIV core clocks. Every SPI pin and status output
// comes straight from a flop.
module spi_reg_master #(
  parameter int CLK_DIV = 25
) (
  input  logic              clk,
  input  logic              reset,
  spi_reg_master_if.slave   bus,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [3:0]       BIT_LAST = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_HOLD     = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [15:0]      tx_sr_r;
  logic [7:0]       rx_sr_r;     // only byte 1 survives; byte-0 bits fall out the top
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic             sclk_r;
  logic             mosi_r;
  logic             ss_r;
  logic             busy_r;
  logic             done_r;
  logic [7:0]       rdata_r;
  logic             phase_end_s;

  assign phase_end_s = (div_cnt_r == DIV_LAST);

  assign sclk      = sclk_r;
  assign mosi      = mosi_r;
  assign ss        = ss_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.rdata = rdata_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode: every non-idle state lasts one half period.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (phase_end_s) begin
          next_state_s = ST_SHIFT_HI;
        end else begin
          next_state_s = ST_SETUP;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_end_s) begin
          next_state_s = ST_SHIFT_LO;
        end else begin
          next_state_s = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_end_s && (bit_cnt_r == BIT_LAST)) begin
          next_state_s = ST_HOLD;
        end else if (phase_end_s) begin
          next_state_s = ST_SHIFT_HI;
        end else begin
          next_state_s = ST_SHIFT_LO;
        end
      end
      ST_HOLD: begin
        if (phase_end_s) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (phase_end_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Half-period counter, restarted at every phase boundary and held in idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= DIV_ZERO;
    end else if ((state_r == ST_IDLE) || phase_end_s) begin
      div_cnt_r <= DIV_ZERO;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Shift registers, bit counter and all registered pin/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr_r   <= 16'h0000;
      rx_sr_r   <= 8'h00;
      bit_cnt_r <= 4'd0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      ss_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rdata_r   <= 8'h00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            tx_sr_r   <= {bus.rw, bus.addr, bus.wdata};
            rx_sr_r   <= 8'h00;
            bit_cnt_r <= 4'd0;
            busy_r    <= 1'b1;
            ss_r      <= 1'b0;
            mosi_r    <= bus.rw;
          end
        end
        ST_SETUP: begin
          if (phase_end_s) begin
            sclk_r <= 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          // Sample as late as possible: the slave moves miso a few clocks
          // after the falling edge, so the last high cycle is the safe one.
          if (phase_end_s) begin
            sclk_r  <= 1'b0;
            rx_sr_r <= {rx_sr_r[6:0], miso};
            tx_sr_r <= {tx_sr_r[14:0], tx_sr_r[15]};
            if (bit_cnt_r != BIT_LAST) begin
              mosi_r <= tx_sr_r[14];
            end
          end
        end
        ST_SHIFT_LO: begin
          if (phase_end_s && (bit_cnt_r != BIT_LAST)) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            sclk_r    <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (phase_end_s) begin
            ss_r    <= 1'b1;
            done_r  <= 1'b1;
            rdata_r <= rx_sr_r;
            mosi_r  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (phase_end_s) begin
            busy_r <= 1'b0;
          end
        end
        default: begin
          sclk_r <= 1'b0;
          ss_r   <= 1'b1;
          mosi_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: three instances (CLK_DIV 2, 1, 25) sharing clock
// and reset. Instance 0 talks to a register-map slave model (0x00 = 0xC2 RO,
// 0x01 RW); instances 1 and 2 get a random 16-bit miso pattern that changes
// only in the first cycle of each low phase.
module tb_spi_reg_master;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sclk_w;
  logic [2:0] mosi_w;
  logic [2:0] ss_w;
  logic [2:0] miso_d = 3'b000;

  int n_chk  = 0;
  int n_fail = 0;

  int kdiv [3] = '{2, 1, 25};

  spi_reg_master_if bus0 ();
  spi_reg_master_if bus1 ();
  spi_reg_master_if bus2 ();

  spi_reg_master #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .sclk(sclk_w[0]), .mosi(mosi_w[0]), .miso(miso_d[0]), .ss(ss_w[0]));
  spi_reg_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .sclk(sclk_w[1]), .mosi(mosi_w[1]), .miso(miso_d[1]), .ss(ss_w[1]));
  spi_reg_master #(.CLK_DIV(25)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .sclk(sclk_w[2]), .mosi(mosi_w[2]), .miso(miso_d[2]), .ss(ss_w[2]));

  always #5 clk = ~clk;

  // ---------------- SPI-side monitor and slave models ----------------
  logic [2:0]  sclk_p = 3'b000;
  logic [2:0]  ss_p   = 3'b111;
  int          rises   [3] = '{0, 0, 0};
  int          run     [3] = '{0, 0, 0};
  int          wid_ok  [3] = '{0, 0, 0};
  int          wid_bad [3] = '{0, 0, 0};
  int          viol    [3] = '{0, 0, 0};
  logic [15:0] mosi_word [3] = '{16'h0000, 16'h0000, 16'h0000};
  logic [15:0] pat       [3] = '{16'h0000, 16'h0000, 16'h0000};
  logic [7:0]  slv_byte1 = 8'h00;
  logic [7:0]  slv_reg1  = 8'h00;

  function automatic logic [7:0] slave_map(input logic [6:0] a, input logic [7:0] r1);
    if (a == 7'd0) return 8'hC2;
    else if (a == 7'd1) return r1;
    else return 8'h00;
  endfunction

  // Watch each SPI port once per cycle: edge counts, phase widths, mosi bits,
  // and drive miso right after each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      sclk_p[i] <= sclk_w[i];
      ss_p[i]   <= ss_w[i];
      if (sclk_w[i] === 1'b1 && ss_w[i] === 1'b1) viol[i] <= viol[i] + 1;
      if (sclk_w[i] !== sclk_p[i]) begin
        run[i] <= 1;
        if (sclk_p[i] === 1'b1 || rises[i] > 0) begin
          if (run[i] == kdiv[i]) wid_ok[i] <= wid_ok[i] + 1;
          else wid_bad[i] <= wid_bad[i] + 1;
        end
      end else begin
        run[i] <= run[i] + 1;
      end
      if (sclk_w[i] === 1'b1 && sclk_p[i] === 1'b0) begin
        rises[i]     <= rises[i] + 1;
        mosi_word[i] <= {mosi_word[i][14:0], mosi_w[i]};
      end
      if (ss_w[i] === 1'b0 && ss_p[i] === 1'b1) begin
        rises[i]   <= 0;
        wid_ok[i]  <= 0;
        wid_bad[i] <= 0;
        miso_d[i]  <= pat[i][15];
      end else if (sclk_w[i] === 1'b0 && sclk_p[i] === 1'b1 && ss_w[i] === 1'b0 && rises[i] < 16) begin
        if (i == 0 && rises[i] == 8) begin
          slv_byte1 <= slave_map(mosi_word[i][6:0], slv_reg1);
          miso_d[i] <= |(slave_map(mosi_word[i][6:0], slv_reg1) & 8'h80);
        end else if (i == 0 && rises[i] > 8) begin
          miso_d[i] <= slv_byte1[3'(15 - rises[i])];
        end else begin
          miso_d[i] <= pat[i][4'(15 - rises[i])];
        end
      end
      if (i == 0 && ss_w[i] === 1'b1 && ss_p[i] === 1'b0 && rises[i] == 16 &&
          mosi_word[i][15] === 1'b1 && mosi_word[i][14:8] == 7'd1)
        slv_reg1 <= mosi_word[i][7:0];
    end
  end

  // ---------------- reference register map ----------------
  logic [7:0] ref_map [128];

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic drive_req(input int idx, input logic st, input logic r,
                           input logic [6:0] a, input logic [7:0] d);
    case (idx)
      0: begin bus0.start = st; bus0.rw = r; bus0.addr = a; bus0.wdata = d; end
      1: begin bus1.start = st; bus1.rw = r; bus1.addr = a; bus1.wdata = d; end
      2: begin bus2.start = st; bus2.rw = r; bus2.addr = a; bus2.wdata = d; end
      default: ;
    endcase
  endtask

  function automatic logic [10:0] obs(input int idx);
    case (idx)
      0: return {ss_w[0], bus0.busy, bus0.done, bus0.rdata};
      1: return {ss_w[1], bus1.busy, bus1.done, bus1.rdata};
      2: return {ss_w[2], bus2.busy, bus2.done, bus2.rdata};
      default: return 11'h000;
    endcase
  endfunction

  // One transaction on instance idx; cycle 0 is the cycle start is high.
  task automatic run_txn(input int idx, input logic r, input logic [6:0] a, input logic [7:0] d,
                         output int ss_first, output int ss_last, output int done_cyc,
                         output int done_cnt, output int busy_first, output int busy_last,
                         output logic [7:0] rd);
    logic [10:0] o;
    int lim;
    lim = 35 * kdiv[idx] + 10;
    ss_first = -1; ss_last = -1; done_cyc = -1; done_cnt = 0;
    busy_first = -1; busy_last = -1; rd = 8'h00;
    @(posedge clk); #1;
    drive_req(idx, 1'b1, r, a, d);
    @(posedge clk); #1;
    drive_req(idx, 1'b0, r, a, d);
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      o = obs(idx);
      if (o[10] === 1'b0) begin if (ss_first < 0) ss_first = n; ss_last = n; end
      if (o[9] === 1'b1) begin if (busy_first < 0) busy_first = n; busy_last = n; end
      if (o[8] === 1'b1) begin done_cnt++; done_cyc = n; rd = o[7:0]; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (ss_w !== 3'b111) begin n_fail++; $display("FAIL reset_ss: got %b want 111", ss_w); end
    n_chk++; if (sclk_w !== 3'b000) begin n_fail++; $display("FAIL reset_sclk: got %b want 000", sclk_w); end
    n_chk++; if (mosi_w !== 3'b000) begin n_fail++; $display("FAIL reset_mosi: got %b want 000", mosi_w); end
    n_chk++; if ({bus2.busy, bus1.busy, bus0.busy} !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b want 000", {bus2.busy, bus1.busy, bus0.busy}); end
    n_chk++; if ({bus2.done, bus1.done, bus0.done} !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b want 000", {bus2.done, bus1.done, bus0.done}); end
    n_chk++; if (bus0.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", bus0.rdata); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_write_timing();
    int sf, sl, dc, dn, bf, bl;
    logic [7:0] rd;
    logic [7:0] exp_rd;
    pat[0] = 16'($urandom);
    exp_rd = ref_map[1];
    run_txn(0, 1'b1, 7'h01, 8'h01, sf, sl, dc, dn, bf, bl, rd);
    ref_map[1] = 8'h01;
    n_chk++; if (sf != 1) begin n_fail++; $display("FAIL wr_ss_first: got %0d want 1", sf); end
    n_chk++; if (sl != 68) begin n_fail++; $display("FAIL wr_ss_last: got %0d want 68", sl); end
    n_chk++; if (dc != 69) begin n_fail++; $display("FAIL wr_done_cycle: got %0d want 69", dc); end
    n_chk++; if (dn != 1) begin n_fail++; $display("FAIL wr_done_count: got %0d want 1", dn); end
    n_chk++; if (bf != 1) begin n_fail++; $display("FAIL wr_busy_first: got %0d want 1", bf); end
    n_chk++; if (bl != 70) begin n_fail++; $display("FAIL wr_busy_last: got %0d want 70", bl); end
    n_chk++; if (rises[0] != 16) begin n_fail++; $display("FAIL wr_rises: got %0d want 16", rises[0]); end
    n_chk++; if (mosi_word[0] !== 16'h8101) begin n_fail++; $display("FAIL wr_mosi: got %h want 8101", mosi_word[0]); end
    n_chk++; if (wid_ok[0] != 31 || wid_bad[0] != 0) begin n_fail++; $display("FAIL wr_widths: got ok=%0d bad=%0d want 31/0", wid_ok[0], wid_bad[0]); end
    n_chk++; if (slv_reg1[0] !== 1'b1) begin n_fail++; $display("FAIL wr_force_pin: got %b want 1", slv_reg1[0]); end
    n_chk++; if (rd !== exp_rd) begin n_fail++; $display("FAIL wr_rdata: got %h want %h", rd, exp_rd); end
  endtask

  task automatic test_read_fw();
    int sf, sl, dc, dn, bf, bl;
    logic [7:0] rd;
    pat[0] = 16'($urandom);
    run_txn(0, 1'b0, 7'h00, 8'h00, sf, sl, dc, dn, bf, bl, rd);
    n_chk++; if (rd !== 8'hC2) begin n_fail++; $display("FAIL fw_rdata: got %h want c2", rd); end
    n_chk++; if (mosi_word[0] !== 16'h0000) begin n_fail++; $display("FAIL fw_mosi: got %h want 0000", mosi_word[0]); end
    repeat (10) @(negedge clk);
    n_chk++; if (bus0.rdata !== 8'hC2) begin n_fail++; $display("FAIL fw_rdata_held: got %h want c2", bus0.rdata); end
  endtask

  task automatic test_rw_reg();
    int sf, sl, dc, dn, bf, bl;
    logic [7:0] rd, exp_rd, d;
    logic [6:0] a;
    logic r;
    for (int k = 0; k < 11; k++) begin
      case (k)
        0: begin r = 1'b0; a = 7'h01; d = 8'($urandom); end
        1: begin r = 1'b1; a = 7'h01; d = 8'h00; end
        2: begin r = 1'b0; a = 7'h01; d = 8'($urandom); end
        default: begin
          r = 1'($urandom);
          a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 1));
          d = 8'($urandom);
        end
      endcase
      pat[0] = 16'($urandom);
      exp_rd = ref_map[a];
      run_txn(0, r, a, d, sf, sl, dc, dn, bf, bl, rd);
      if (r && a == 7'h01) ref_map[1] = d;
      n_chk++; if (rd !== exp_rd || dn != 1) begin n_fail++; $display("FAIL rw_rdata[%0d]: got %h (done x%0d) want %h (done x1)", k, rd, dn, exp_rd); end
      n_chk++; if (mosi_word[0] !== {r, a, d}) begin n_fail++; $display("FAIL rw_mosi[%0d]: got %h want %h", k, mosi_word[0], {r, a, d}); end
    end
    n_chk++; if (slv_reg1 !== ref_map[1]) begin n_fail++; $display("FAIL rw_slave_reg1: got %h want %h", slv_reg1, ref_map[1]); end
  endtask

  task automatic test_back_to_back();
    int dones, first_done, second_done, ss2_first;
    logic busy71, busy72;
    logic [10:0] o;
    dones = 0; first_done = -1; second_done = -1; ss2_first = -1;
    busy71 = 1'bx; busy72 = 1'bx;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 7'h00, 8'h00);
    for (int n = 1; n <= 150; n++) begin
      @(posedge clk); #1;
      drive_req(0, (n == 5 || n == 30 || (n >= 60 && n <= 72)), 1'b0, 7'h00, 8'h00);
      @(negedge clk);
      o = obs(0);
      if (o[8] === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = n; else second_done = n;
      end
      if (n > 68 && o[10] === 1'b0 && ss2_first < 0) ss2_first = n;
      if (n == 71) busy71 = o[9];
      if (n == 72) busy72 = o[9];
    end
    n_chk++; if (first_done != 69) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 69", first_done); end
    n_chk++; if (busy71 !== 1'b0 || busy72 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_71_72: got %b%b want 01", busy71, busy72); end
    n_chk++; if (ss2_first != 72) begin n_fail++; $display("FAIL b2b_second_ss: got %0d want 72", ss2_first); end
    n_chk++; if (dones != 2 || second_done != 140) begin n_fail++; $display("FAIL b2b_dones: got %0d at %0d want 2 at 140", dones, second_done); end
  endtask

  task automatic test_reset_mid();
    int sf, sl, dc, dn, bf, bl, dr;
    logic [7:0] rd;
    logic busy_pre;
    busy_pre = 1'b0; dr = 0;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 7'h01, 8'h00);
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk); #1;
      drive_req(0, 1'b0, 1'b0, 7'h01, 8'h00);
      @(negedge clk);
      if (n == 19) busy_pre = bus0.busy;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_chk++; if (busy_pre !== 1'b1) begin n_fail++; $display("FAIL rst_mid_active: got %b want 1", busy_pre); end
    n_chk++; if (ss_w[0] !== 1'b1 || sclk_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pins: got ss=%b sclk=%b want 1/0", ss_w[0], sclk_w[0]); end
    n_chk++; if (bus0.busy !== 1'b0 || bus0.rdata !== 8'h00) begin n_fail++; $display("FAIL rst_mid_status: got busy=%b rdata=%h want 0/00", bus0.busy, bus0.rdata); end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (bus0.done !== 1'b0) dr++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(negedge clk); if (bus0.done !== 1'b0) dr++; end
    n_chk++; if (dr != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d want 0", dr); end
    pat[0] = 16'($urandom);
    run_txn(0, 1'b0, 7'h00, 8'h00, sf, sl, dc, dn, bf, bl, rd);
    n_chk++; if (rd !== 8'hC2 || dn != 1 || dc != 69) begin n_fail++; $display("FAIL rst_mid_recover: got %h x%0d @%0d want c2 x1 @69", rd, dn, dc); end
  endtask

  task automatic test_clk_div();
    int sf, sl, dc, dn, bf, bl, k;
    logic [7:0] rd, d;
    logic [6:0] a;
    logic r;
    for (int idx = 1; idx <= 2; idx++) begin
      for (int it = 0; it < 2; it++) begin
        k = kdiv[idx];
        r = 1'($urandom); a = 7'($urandom); d = 8'($urandom);
        pat[idx] = 16'($urandom);
        run_txn(idx, r, a, d, sf, sl, dc, dn, bf, bl, rd);
        n_chk++; if (rd !== pat[idx][7:0] || dn != 1) begin n_fail++; $display("FAIL div%0d_rdata: got %h x%0d want %h x1", k, rd, dn, pat[idx][7:0]); end
        n_chk++; if (mosi_word[idx] !== {r, a, d}) begin n_fail++; $display("FAIL div%0d_mosi: got %h want %h", k, mosi_word[idx], {r, a, d}); end
        n_chk++; if (rises[idx] != 16 || wid_ok[idx] != 31 || wid_bad[idx] != 0) begin n_fail++; $display("FAIL div%0d_widths: got rises=%0d ok=%0d bad=%0d want 16/31/0", k, rises[idx], wid_ok[idx], wid_bad[idx]); end
        n_chk++; if (bf != 1 || bl != 35 * k || dc != 34 * k + 1 || sl != 34 * k) begin n_fail++; $display("FAIL div%0d_timing: got busy %0d..%0d done %0d ss_last %0d want 1..%0d %0d %0d", k, bf, bl, dc, sl, 35 * k, 34 * k + 1, 34 * k); end
      end
    end
    n_chk++; if (viol[0] + viol[1] + viol[2] != 0) begin n_fail++; $display("FAIL sclk_with_ss_high: got %0d want 0", viol[0] + viol[1] + viol[2]); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_map[i] = 8'h00;
    ref_map[0] = 8'hC2;
    drive_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
    drive_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
    drive_req(2, 1'b0, 1'b0, 7'h00, 8'h00);
    test_reset();
    test_write_timing();
    test_read_fw();
    test_rw_reg();
    test_back_to_back();
    test_reset_mid();
    test_clk_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
